// File: rtl/bn_param_loader.sv
// Serial-to-parallel loader for batch-norm gamma, moving-mean and denominator vectors.
// Optional macro BN_PARAM_ZERO_DENOM_CHECK_EN enables the sticky zero-denominator flag on error_o.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | no parameters loaded since reset, waiting for start_i
// LOAD_GAMMA | accepting gamma words k=0..N-1
// LOAD_MEAN  | accepting moving-mean words k=0..N-1
// LOAD_DENOM | accepting denominator words k=0..N-1
// DONE       | all three vectors complete and held, waiting for start_i
module bn_param_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int INPUT      = 30
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                start_i,
    input  logic [DATA_WIDTH-1:0]               word_i,
    input  logic                                word_valid_i,
    output logic                                word_ready_o,
    output logic [INPUT*INPUT*DATA_WIDTH-1:0]   gamma_o,
    output logic [INPUT*INPUT*DATA_WIDTH-1:0]   moving_means_o,
    output logic [INPUT*INPUT*DATA_WIDTH-1:0]   denominators_o,
    output logic                                params_valid_o,
    output logic                                busy_o,
    output logic                                error_o
);

    localparam int N  = INPUT * INPUT;
    localparam int VW = N * DATA_WIDTH;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int OW = (VW > 1) ? $clog2(VW) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_GAMMA,
        LOAD_MEAN,
        LOAD_DENOM,
        DONE
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [VW-1:0]   gamma_q;
    logic [VW-1:0]   mean_q;
    logic [VW-1:0]   denom_q;
    logic            ready_q;
    logic            busy_q;
    logic            valid_q;
    logic [OW-1:0]   slice_off_d;
    logic            last_d;

    always_comb begin
        slice_off_d = OW'(cnt_q) * OW'(DATA_WIDTH);
        last_d      = (cnt_q == CW'(N - 1));
    end

`ifdef BN_PARAM_ZERO_DENOM_CHECK_EN
    logic error_q;
    assign error_o = error_q;
`else
    assign error_o = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gamma_q <= '0;
            mean_q  <= '0;
            denom_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
`ifdef BN_PARAM_ZERO_DENOM_CHECK_EN
            error_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        state_q <= LOAD_GAMMA;
                        cnt_q   <= '0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b1;
                        valid_q <= 1'b0;
`ifdef BN_PARAM_ZERO_DENOM_CHECK_EN
                        error_q <= 1'b0;
`endif
                    end
                end
                LOAD_GAMMA: begin
                    if (word_valid_i) begin
                        gamma_q[slice_off_d +: DATA_WIDTH] <= word_i;
                        cnt_q <= last_d ? '0 : cnt_q + 1'b1;
                        if (last_d) state_q <= LOAD_MEAN;
                    end
                end
                LOAD_MEAN: begin
                    if (word_valid_i) begin
                        mean_q[slice_off_d +: DATA_WIDTH] <= word_i;
                        cnt_q <= last_d ? '0 : cnt_q + 1'b1;
                        if (last_d) state_q <= LOAD_DENOM;
                    end
                end
                LOAD_DENOM: begin
                    if (word_valid_i) begin
                        denom_q[slice_off_d +: DATA_WIDTH] <= word_i;
                        cnt_q <= last_d ? '0 : cnt_q + 1'b1;
`ifdef BN_PARAM_ZERO_DENOM_CHECK_EN
                        // Sign bit ignored so that -0.0 is flagged too.
                        if (word_i[DATA_WIDTH-2:0] == '0) error_q <= 1'b1;
`endif
                        if (last_d) begin
                            state_q <= DONE;
                            ready_q <= 1'b0;
                            busy_q  <= 1'b0;
                            valid_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign word_ready_o   = ready_q;
    assign busy_o         = busy_q;
    assign params_valid_o = valid_q;
    assign gamma_o        = gamma_q;
    assign moving_means_o = mean_q;
    assign denominators_o = denom_q;

endmodule

// File: tb/tb_bn_param_loader.sv
// Directed bench for bn_param_loader with INPUT=2 (N=4); tracks expected vectors in a small model.
module tb_bn_param_loader;

    localparam int DW = 32;
    localparam int N  = 4;
    localparam int VW = N * DW;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start_i;
    logic [DW-1:0] word_i;
    logic          word_valid_i;
    logic          word_ready_o;
    logic [VW-1:0] gamma_o;
    logic [VW-1:0] moving_means_o;
    logic [VW-1:0] denominators_o;
    logic          params_valid_o;
    logic          busy_o;
    logic          error_o;

    int checks = 0;
    int errors = 0;

    logic [VW-1:0] exp_g, exp_m, exp_d;
    logic          exp_err;

    bn_param_loader #(.DATA_WIDTH(DW), .INPUT(2)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start_i        (start_i),
        .word_i         (word_i),
        .word_valid_i   (word_valid_i),
        .word_ready_o   (word_ready_o),
        .gamma_o        (gamma_o),
        .moving_means_o (moving_means_o),
        .denominators_o (denominators_o),
        .params_valid_o (params_valid_o),
        .busy_o         (busy_o),
        .error_o        (error_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input string name);
        start_i      = 1'b1;
        word_valid_i = 1'b0;
        tick();
        start_i = 1'b0;
        exp_err = 1'b0;
        checks++;
        if ({word_ready_o, busy_o, params_valid_o, error_o} !== 4'b1100) begin
            errors++;
            $display("FAIL %s start: ready/busy/pv/err=%b expected 1100", name,
                     {word_ready_o, busy_o, params_valid_o, error_o});
        end
    endtask

    // Drives words base+idx until stop_after words are accepted, checking every cycle.
    task automatic load(input string name, input logic [DW-1:0] base, input bit gaps,
                        input int mid_start_at, input int zero_at, input int stop_after,
                        output int cycles);
        int  idx;
        bit  acc;
        bit  fired;
        logic [DW-1:0] w;
        idx = 0; cycles = 0; fired = 1'b0;
        while (idx < stop_after && cycles < 200) begin
            w = (idx == zero_at) ? 32'h8000_0000 : base + DW'(idx);
            word_i       = w;
            word_valid_i = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (idx == mid_start_at && !fired) begin
                start_i = 1'b1;
                fired   = 1'b1;
            end
            acc = word_valid_i && word_ready_o;
            tick();
            cycles++;
            start_i = 1'b0;
            if (acc) begin
                case (idx / N)
                    0: exp_g[(idx % N)*DW +: DW] = w;
                    1: exp_m[(idx % N)*DW +: DW] = w;
                    default: exp_d[(idx % N)*DW +: DW] = w;
                endcase
`ifdef BN_PARAM_ZERO_DENOM_CHECK_EN
                if (idx >= 2*N && w[DW-2:0] == '0) exp_err = 1'b1;
`endif
                idx++;
            end
            checks++;
            if (gamma_o !== exp_g || moving_means_o !== exp_m || denominators_o !== exp_d) begin
                errors++;
                $display("FAIL %s vectors idx=%0d: g=%h m=%h d=%h expected g=%h m=%h d=%h",
                         name, idx, gamma_o, moving_means_o, denominators_o, exp_g, exp_m, exp_d);
            end
            checks++;
            if ({word_ready_o, busy_o, params_valid_o, error_o} !==
                {idx < 3*N, idx < 3*N, idx == 3*N, exp_err}) begin
                errors++;
                $display("FAIL %s flags idx=%0d: ready/busy/pv/err=%b expected %b", name, idx,
                         {word_ready_o, busy_o, params_valid_o, error_o},
                         {idx < 3*N, idx < 3*N, idx == 3*N, exp_err});
            end
        end
        word_valid_i = 1'b0;
        checks++;
        if (idx != stop_after) begin
            errors++;
            $display("FAIL %s timeout: accepted %0d words expected %0d", name, idx, stop_after);
        end
    endtask

    task automatic hold_done(input string name);
        for (int i = 0; i < 3; i++) begin
            word_valid_i = 1'b1;
            word_i       = $urandom;
            tick();
            checks++;
            if (gamma_o !== exp_g || moving_means_o !== exp_m || denominators_o !== exp_d
                || params_valid_o !== 1'b1 || busy_o !== 1'b0 || error_o !== exp_err) begin
                errors++;
                $display("FAIL %s hold: pv=%b busy=%b err=%b g=%h expected pv=1 busy=0 err=%b g=%h",
                         name, params_valid_o, busy_o, error_o, gamma_o, exp_err, exp_g);
            end
        end
        word_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start_i      = 1'($urandom);
            word_valid_i = 1'($urandom);
            word_i       = $urandom;
            tick();
        end
        start_i = 1'b0; word_valid_i = 1'b0; word_i = '0;
        exp_g = '0; exp_m = '0; exp_d = '0; exp_err = 1'b0;
        checks++;
        if ({word_ready_o, busy_o, params_valid_o, error_o} !== 4'b0000) begin
            errors++;
            $display("FAIL reset flags: %b expected 0000",
                     {word_ready_o, busy_o, params_valid_o, error_o});
        end
        checks++;
        if (gamma_o !== '0 || moving_means_o !== '0 || denominators_o !== '0) begin
            errors++;
            $display("FAIL reset vectors: g=%h m=%h d=%h expected zero",
                     gamma_o, moving_means_o, denominators_o);
        end
        reset_n = 1'b1;
        word_valid_i = 1'b1;
        word_i = 32'hDEAD_BEEF;
        tick();
        word_valid_i = 1'b0;
        checks++;
        if (gamma_o !== '0 || busy_o !== 1'b0 || word_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_ignore: g=%h busy=%b ready=%b expected zero", gamma_o, busy_o, word_ready_o);
        end
    endtask

    task automatic test_full_load();
        int cyc;
        do_start("full");
        load("full", 32'd1, 1'b0, -1, -1, 3*N, cyc);
        checks++;
        if (cyc + 1 != 13) begin
            errors++;
            $display("FAIL full latency: %0d cycles expected 13", cyc + 1);
        end
        checks++;
        if (gamma_o !== {32'd4, 32'd3, 32'd2, 32'd1} ||
            moving_means_o !== {32'd8, 32'd7, 32'd6, 32'd5} ||
            denominators_o !== {32'd12, 32'd11, 32'd10, 32'd9}) begin
            errors++;
            $display("FAIL full values: g=%h m=%h d=%h expected 1..12",
                     gamma_o, moving_means_o, denominators_o);
        end
        hold_done("full");
    endtask

    task automatic test_reload();
        int cyc;
        do_start("reload");
        load("reload", 32'd101, 1'b0, -1, -1, 3*N, cyc);
        checks++;
        if (denominators_o !== {32'd112, 32'd111, 32'd110, 32'd109} ||
            gamma_o !== {32'd104, 32'd103, 32'd102, 32'd101}) begin
            errors++;
            $display("FAIL reload values: g=%h d=%h expected 101..112", gamma_o, denominators_o);
        end
        hold_done("reload");
    endtask

    task automatic test_backpressure();
        int cyc;
        do_start("bp");
        load("bp", 32'd301, 1'b1, 5, -1, 3*N, cyc);
        checks++;
        if (moving_means_o !== {32'd308, 32'd307, 32'd306, 32'd305}) begin
            errors++;
            $display("FAIL bp means: %h expected 305..308", moving_means_o);
        end
        hold_done("bp");
    endtask

    task automatic test_reset_mid_load();
        int cyc;
        do_start("midrst");
        load("midrst", 32'd401, 1'b0, -1, -1, 6, cyc);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        exp_g = '0; exp_m = '0; exp_d = '0; exp_err = 1'b0;
        checks++;
        if ({word_ready_o, busy_o, params_valid_o, error_o} !== 4'b0000 ||
            gamma_o !== '0 || moving_means_o !== '0 || denominators_o !== '0) begin
            errors++;
            $display("FAIL midrst abort: flags=%b g=%h m=%h expected all zero",
                     {word_ready_o, busy_o, params_valid_o, error_o}, gamma_o, moving_means_o);
        end
        do_start("after_rst");
        load("after_rst", 32'd201, 1'b0, -1, -1, 3*N, cyc);
        hold_done("after_rst");
    endtask

    task automatic test_zero_denom();
        int cyc;
        do_start("zden");
        load("zden", 32'd501, 1'b0, -1, 2*N + 2, 3*N, cyc);
        checks++;
`ifdef BN_PARAM_ZERO_DENOM_CHECK_EN
        if (error_o !== 1'b1) begin
`else
        if (error_o !== 1'b0) begin
`endif
            errors++;
            $display("FAIL zden done: error_o=%b", error_o);
        end
        hold_done("zden");
        do_start("zden_clear");
        load("zden_clear", 32'd601, 1'b0, -1, -1, 3*N, cyc);
    endtask

    initial begin
        start_i = 1'b0; word_valid_i = 1'b0; word_i = '0; reset_n = 1'b0;
        exp_g = '0; exp_m = '0; exp_d = '0; exp_err = 1'b0;
        test_reset();
        test_full_load();
        test_reload();
        test_backpressure();
        test_reset_mid_load();
        test_zero_denom();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
